// File: rtl/synch_counter_pkg.sv
// Shared types and constants for the synchronous down-counter.
// Defaults target simulation; BOARD_PRESCALE_1HZ gives 1 Hz at 50 MHz.
package synch_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH          = 4;
  localparam int DEF_PRESCALE       = 4;
  localparam int BOARD_PRESCALE_1HZ = 50_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE; tick is decoded from the register.
// clr returns the divider to zero without producing a tick.
module tick_prescaler #(
  parameter int PRESCALE = 4,
  parameter int PS_W     = $clog2(PRESCALE + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [PS_W-1:0] ps;

  assign tick = en && (ps == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ps <= '0;
    end else if (en) begin
      if (tick) ps <= '0;
      else      ps <= ps + 1'b1;
    end
  end

endmodule

// File: rtl/synch_downcounter.sv
// Prescaled loadable down-counter with tc pulse and LED toggle.
// Define SYNCH_DOWNCOUNTER_ONESHOT_EN to stop in DONE instead of reloading.
module synch_downcounter
  import synch_counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int PS_W     = $clog2(PRESCALE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             led,
  output logic             busy
);

  state_t           state, state_n;
  logic [WIDTH-1:0] reload, reload_n, count_n;
  logic             tc_n, led_n, tick;

  // Load clears the divider and pre-empts any tick in the same cycle.
  tick_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_ps (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (en && !load && (state == ST_RUN)),
    .tick (tick)
  );

  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload;
    tc_n     = 1'b0;
    led_n    = led;
    if (load) begin
      count_n  = load_val;
      reload_n = load_val;
      state_n  = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (en) state_n = ST_RUN;
        ST_RUN: begin
          if (tick) begin
            if (count != '0) begin
              count_n = count - 1'b1;
            end else begin
              tc_n = 1'b1;
`ifdef SYNCH_DOWNCOUNTER_ONESHOT_EN
              state_n = ST_DONE;
              led_n   = 1'b1;
`else
              count_n = reload;
              led_n   = ~led;
`endif
            end
          end
        end
`ifdef SYNCH_DOWNCOUNTER_ONESHOT_EN
        ST_DONE: state_n = ST_DONE;
`endif
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '1;
      reload <= '1;
      tc     <= 1'b0;
      led    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      reload <= reload_n;
      tc     <= tc_n;
      led    <= led_n;
      busy   <= (state_n == ST_RUN);
    end
  end

endmodule
